// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port integer register file.
//   calc_aw   : address width for a given register count
//   NRD_MAX   : largest supported number of read ports
//   NWR_MAX   : largest supported number of write ports
//   reg_adr_t : register address type for the default 32-entry file
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NRD_MAX = 4;
    localparam int NWR_MAX = 2;

    // Address width needed to select one of 'depth' registers.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEFAULT_AW = calc_aw(32);

    typedef logic [DEFAULT_AW-1:0] reg_adr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Decode/writeback side bus of the register file.
//   REGWRITE   : per write port enable
//   ADR_WR_REG : per write port destination address
//   WR_DATA    : per write port data
//   ADR_REG    : per read port source address
//   REG_DATA   : per read port data (combinational)
//   REG_BUSY   : per read port pending-write flag
//   ISSUE      : mark ADR_ISSUE as having a pending producer
//   ADR_ISSUE  : destination register of the issuing instruction
//   FLUSH      : clear every pending-write flag
// master = pipeline side, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    import regfile_pkg::*;

    localparam int AW = calc_aw(DEPTH);

    logic [NWR-1:0]            REGWRITE;
    logic [NWR-1:0][AW-1:0]    ADR_WR_REG;
    logic [NWR-1:0][WIDTH-1:0] WR_DATA;
    logic [NRD-1:0][AW-1:0]    ADR_REG;
    logic [NRD-1:0][WIDTH-1:0] REG_DATA;
    logic [NRD-1:0]            REG_BUSY;
    logic                      ISSUE;
    logic [AW-1:0]             ADR_ISSUE;
    logic                      FLUSH;

    modport master (
        output REGWRITE, ADR_WR_REG, WR_DATA, ADR_REG, ISSUE, ADR_ISSUE, FLUSH,
        input  REG_DATA, REG_BUSY
    );

    modport slave (
        input  REGWRITE, ADR_WR_REG, WR_DATA, ADR_REG, ISSUE, ADR_ISSUE, FLUSH,
        output REG_DATA, REG_BUSY
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One pending-write bit per register so decode can spot RAW hazards.
//   clk, rst     : clock, asynchronous active-low reset
//   regwrite_i   : per write port enable
//   adr_wr_i     : per write port address
//   issue_i      : set the busy bit of adr_issue_i
//   adr_issue_i  : destination of the issuing instruction
//   flush_i      : clear all busy bits
//   adr_rd_i     : per read port address
//   busy_o       : per read port busy flag
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = 32,
    parameter  int NWR    = 1,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = calc_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         regwrite_i,
    input  logic [NWR-1:0][AW-1:0] adr_wr_i,
    input  logic                   issue_i,
    input  logic [AW-1:0]          adr_issue_i,
    input  logic                   flush_i,
    input  logic [NRD-1:0][AW-1:0] adr_rd_i,
    output logic [NRD-1:0]         busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] wrHit;

    // Which registers are written this cycle; x0 is never a real target.
    always_comb begin
        wrHit = '0;
        for (int p = 0; p < NWR; p++) begin
            if (regwrite_i[p]) begin
                wrHit[adr_wr_i[p]] = 1'b1;
            end
        end
        wrHit[0] = 1'b0;
    end

    // Per register: flush beats issue, issue beats writeback clear.
    // Issue winning over writeback means a newer producer keeps ownership.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (issue_i && (adr_issue_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wrHit[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy state; reset leaves every register free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // With bypass, a register whose busy bit is being cleared by a write
    // this cycle already reads free, matching the forwarded data.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            busy_o[r] = busy_q[adr_rd_i[r]];
            if ((BYPASS != 0) && wrHit[adr_rd_i[r]] && !busy_d[adr_rd_i[r]]) begin
                busy_o[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with write-to-read bypass and a
// pending-write scoreboard. x0 reads zero, is never written, never busy.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset
//   bus : regfile_mp_if slave (write ports, read ports, issue/flush)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = calc_aw(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    // Entry 0 has no storage; it is decoded to zero on the read path.
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [NRD-1:0][WIDTH-1:0] rdData;
    logic [NRD-1:0] rdBusy;

    // Storage update. Ports are visited in ascending order so the
    // higher-index port wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.REGWRITE[p] && (bus.ADR_WR_REG[p] != '0)) begin
                    regs_q[bus.ADR_WR_REG[p]] <= bus.WR_DATA[p];
                end
            end
        end
    end

    // Read muxes. Forwarding is suppressed during reset so the outputs
    // stay zero even while a write is still being presented.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rdData[r] = '0;
            if (bus.ADR_REG[r] != '0) begin
                rdData[r] = regs_q[bus.ADR_REG[r]];
                if ((BYPASS != 0) && rst) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (bus.REGWRITE[p] && (bus.ADR_WR_REG[p] == bus.ADR_REG[r])) begin
                            rdData[r] = bus.WR_DATA[p];
                        end
                    end
                end
            end
        end
    end

    assign bus.REG_DATA = rdData;
    assign bus.REG_BUSY = rdBusy;

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NWR    (NWR),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) uScoreboard (
        .clk         (clk),
        .rst         (rst),
        .regwrite_i  (bus.REGWRITE),
        .adr_wr_i    (bus.ADR_WR_REG),
        .issue_i     (bus.ISSUE),
        .adr_issue_i (bus.ADR_ISSUE),
        .flush_i     (bus.FLUSH),
        .adr_rd_i    (bus.ADR_REG),
        .busy_o      (rdBusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives a bypassing and a non-bypassing register file (both two write and
// two read ports) with the same stimulus and compares them to a reference
// model of architectural register state and pending-write flags.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk;
    logic rst;

    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic [1:0][4:0]  ra;
    logic             iss;
    reg_adr_t         ia;
    logic             fl;

    int checks;
    int failures;

    logic [31:0] mem [32];
    bit          busyM [32];

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2)) ifB ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2)) ifN ();

    assign ifB.REGWRITE   = we;
    assign ifB.ADR_WR_REG = wa;
    assign ifB.WR_DATA    = wd;
    assign ifB.ADR_REG    = ra;
    assign ifB.ISSUE      = iss;
    assign ifB.ADR_ISSUE  = ia;
    assign ifB.FLUSH      = fl;
    assign ifN.REGWRITE   = we;
    assign ifN.ADR_WR_REG = wa;
    assign ifN.WR_DATA    = wd;
    assign ifN.ADR_REG    = ra;
    assign ifN.ISSUE      = iss;
    assign ifN.ADR_ISSUE  = ia;
    assign ifN.FLUSH      = fl;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(0)) dutN (
        .clk (clk),
        .rst (rst),
        .bus (ifN)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison with its own counters.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // True when an enabled write port targets register a this cycle.
    function automatic bit writtenTo(input int a);
        bit hit;
        hit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (we[p] && (int'(wa[p]) == a) && (a != 0)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Busy flag register a will hold after the coming edge.
    function automatic bit nextBusy(input int a);
        if (a == 0) return 1'b0;
        if (fl) return 1'b0;
        if (iss && (int'(ia) == a)) return 1'b1;
        if (writtenTo(a)) return 1'b0;
        return busyM[a];
    endfunction

    // Compare both DUTs' read ports against the model for current inputs.
    task automatic checkOutput(input string ph);
        int          a;
        logic [31:0] expN;
        logic [31:0] expB;
        logic        bsyN;
        logic        bsyB;
        for (int r = 0; r < 2; r++) begin
            a    = int'(ra[r]);
            expN = (!rst || a == 0) ? 32'h0 : mem[a];
            expB = expN;
            if (rst && a != 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && int'(wa[p]) == a) expB = wd[p];
                end
            end
            bsyN = rst ? busyM[a] : 1'b0;
            bsyB = bsyN && !(writtenTo(a) && !nextBusy(a));
            checkVal($sformatf("%s.byp.data%0d", ph, r), ifB.REG_DATA[r], expB);
            checkVal($sformatf("%s.nob.data%0d", ph, r), ifN.REG_DATA[r], expN);
            checkVal($sformatf("%s.byp.busy%0d", ph, r), {31'h0, ifB.REG_BUSY[r]}, {31'h0, bsyB});
            checkVal($sformatf("%s.nob.busy%0d", ph, r), {31'h0, ifN.REG_BUSY[r]}, {31'h0, bsyN});
        end
    endtask

    // Advance the model across one rising edge.
    task automatic updateModel();
        bit nb [32];
        for (int i = 0; i < 32; i++) nb[i] = nextBusy(i);
        for (int p = 0; p < 2; p++) begin
            if (we[p] && wa[p] != 5'd0) mem[wa[p]] = wd[p];
        end
        for (int i = 0; i < 32; i++) busyM[i] = nb[i];
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) begin
            mem[i]   = 32'h0;
            busyM[i] = 1'b0;
        end
    endtask

    // Present one cycle of inputs, check mid-cycle, then take the edge.
    task automatic applyStimulus(input logic [1:0] weI,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic issI, input logic [4:0] iaI,
                                 input logic flI, input string ph);
        we    = weI;
        wa[0] = wa0;
        wd[0] = wd0;
        wa[1] = wa1;
        wd[1] = wd1;
        ra[0] = ra0;
        ra[1] = ra1;
        iss   = issI;
        ia    = iaI;
        fl    = flI;
        #2;
        checkOutput(ph);
        @(posedge clk);
        if (rst) updateModel();
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clearModel();
        rst = 1'b0;
        we  = '0;
        wa  = '0;
        wd  = '0;
        ra  = '0;
        iss = 1'b0;
        ia  = '0;
        fl  = 1'b0;

        #2;
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Write x5, issue x12, then reset in the middle of a cycle that
        // also presents a write to x5.
        applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd12, 1'b1, 5'd12, 1'b0, "wrX5");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd0, 1'b0, "rdX5");
        we    = 2'b01;
        wa[0] = 5'd5;
        wd[0] = 32'h11111111;
        ra[0] = 5'd5;
        ra[1] = 5'd12;
        #2;
        checkOutput("preRst");
        rst = 1'b0;
        clearModel();
        #1;
        checkOutput("midRst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd0, 1'b0, "postRst");

        // x0 is never written and never busy.
        applyStimulus(2'b11, 5'd0, 32'h12345678, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, "wrX0");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "rdX0");

        // Same-cycle bypass on read port 1.
        applyStimulus(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, "bypX3");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, "rdX3");

        // Write collision: port 1 wins.
        applyStimulus(2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0, "colX7");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, "rdX7");

        // Scoreboard: issue, issue+write, write alone.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, "issX9");
        applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0, "issWrX9");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, "busyX9");
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h9A, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, "wrX9");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, "freeX9");

        // Flush beats a same-cycle issue.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd4, 1'b0, "issX4");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b0, "issX6");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd8, 1'b0, "issX8");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd10, 1'b1, 5'd10, 1'b1, "flush");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd10, 1'b0, 5'd0, 1'b0, "postFl1");
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0, "postFl2");

        // Random traffic over a narrow address range to provoke collisions,
        // forwarding and issue/writeback overlaps.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 15)), $urandom(),
                          5'($urandom_range(0, 15)), $urandom(),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                          ($urandom_range(0, 15) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined RISC-V core, sitting between decode (read and issue) and writeback. It generalises the single-write/dual-read bank to NRD read ports and NWR write ports on the rising edge, with same-cycle write-to-read bypass. It adds a per-register pending-write scoreboard so decode can detect RAW hazards without a separate hazard unit. Register x0 reads as zero, is never written and is never busy.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; power of two, ≥2; AW = $clog2(DEPTH)
- NRD, 2, number of read ports, 1..4
- NWR, 1, number of write ports, 1..2
- BYPASS, 1, 1 = write data forwarded combinationally to same-cycle reads; 0 = no forwarding
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- REGWRITE  in  NWR  per-port write enable
- ADR_WR_REG  in  NWR×AW  per-port write address
- WR_DATA  in  NWR×WIDTH  per-port write data
- ADR_REG  in  NRD×AW  per-port read address
- REG_DATA  out  NRD×WIDTH  per-port read data, combinational
- REG_BUSY  out  NRD  per-port: addressed register has a pending write
- ISSUE  in  1  mark ADR_ISSUE as pending
- ADR_ISSUE  in  AW  destination register of the issuing instruction
- FLUSH  in  1  synchronous clear of all busy bits

## Operation
- Storage: DEPTH-1 registers of WIDTH bits (x1..x(DEPTH-1)). Entry 0 is not implemented as storage and always reads as 0.
- Write: on the rising edge, each port p with REGWRITE[p]=1 and ADR_WR_REG[p]≠0 writes WR_DATA[p]. A write to x0 is ignored silently.
- Write collision (two ports, same nonzero address, both enabled): the higher-index port wins.
- Read: REG_DATA[r] = 0 if ADR_REG[r]=0.
  - Otherwise, when BYPASS=1 and any enabled write port targets ADR_REG[r] this cycle, the output is that port's WR_DATA, with the highest-index match winning.
  - Otherwise the output is the stored value.
- Scoreboard: one busy bit per register; bit 0 is tied to 0. Per register, in priority order each cycle:
  1. FLUSH=1 → 0
  2. ISSUE=1 with ADR_ISSUE = this register (≠0) → 1
  3. an enabled write port targeting this register → 0
  4. otherwise hold
- Issue and writeback to the same register in the same cycle: the data is written and busy ends at 1, because the new producer owns the register.
- FLUSH has priority over a same-cycle ISSUE. Writes still occur during FLUSH.
- REG_BUSY[r] = busy[ADR_REG[r]] from registered state. When BYPASS=1 and a write clears that register this cycle, REG_BUSY[r] reads 0 in the same cycle.

## Timing
- Reset (rst=0, asynchronous): all registers = 0 and all busy bits = 0 immediately. REG_DATA = 0 and REG_BUSY = 0 for every port. Writes and issues are ignored while rst=0.
- Reset release is synchronous to clk from the first rising edge with rst=1.
- Write latency: the data is visible on reads in the same cycle when BYPASS=1, otherwise in the cycle after the edge.
- Issue latency: busy is visible from the cycle after the ISSUE edge.
- The read path is purely combinational: address → data, no clock edge.
- A reset asserted mid-cycle overrides any pending write on the next edge.

## Structure
- Package regfile_pkg holds:
  - the AW helper function
  - the localparam limits NRD_MAX=4 and NWR_MAX=2
  - typedef reg_adr_t (logic [AW-1:0] for the default DEPTH)
- Sub-module regfile_scoreboard (DEPTH, NWR) holds:
  - busy-bit state
  - issue/clear/flush priority logic
  - the bypass-aware busy lookup per read port
- regfile_mp instantiates regfile_scoreboard once and owns the storage and data bypass muxes.

## Test plan
- Reset: write x5 = 0xDEADBEEF, assert rst=0 mid-cycle → REG_DATA for x5 = 0 immediately, REG_BUSY = 0 on all ports.
- x0: write x0 = 0x12345678 on both ports → all reads of x0 = 0; ISSUE to x0 → REG_BUSY stays 0.
- Bypass (BYPASS=1): in the same cycle write x3 = 0xA5A5A5A5 and read x3 on port 1 → 0xA5A5A5A5 that cycle. With BYPASS=0 the read shows the old value, then 0xA5A5A5A5 next cycle.
- Collision (NWR=2): port0 x7 = 0x1, port1 x7 = 0x2 in the same cycle → x7 = 0x2 on the following cycles.
- Scoreboard: ISSUE x9 → busy next cycle; write x9 with ISSUE x9 in the same cycle → busy stays 1; write x9 alone → busy 0 (same cycle with bypass).
- Flush: ISSUE x4, x6, x8 over three cycles, then FLUSH together with ISSUE x10 → all busy bits 0 next cycle, including x10.
